// File: rtl/vt512_pkg.sv
`default_nettype none
// ===========================================================================
// vt512_pkg : address map, STATUS layout and FSM encoding for vt512_ctrl
// Revision  : 1.0
// ===========================================================================
package vt512_pkg;

   localparam logic [15:0] c_base       = 16'h414E;

   localparam logic [7:0]  c_rgn_ctrl   = 8'h00;
   localparam logic [7:0]  c_rgn_wgt    = 8'h57;
   localparam logic [7:0]  c_rgn_bias   = 8'h42;
   localparam logic [7:0]  c_rgn_img    = 8'h49;

   // Control registers by word index (byte offset >> 2)
   localparam logic [5:0]  c_ofs_ctrl   = 6'd0;
   localparam logic [5:0]  c_ofs_status = 6'd1;
   localparam logic [5:0]  c_ofs_size   = 6'd2;
   localparam logic [5:0]  c_ofs_cnt    = 6'd3;

   localparam int c_st_done = 2;
   localparam int c_st_ovf  = 3;
   localparam int c_st_serr = 4;

   localparam int c_sel_ctrl = 0;
   localparam int c_sel_wgt  = 1;
   localparam int c_sel_bias = 2;
   localparam int c_sel_img  = 3;
   localparam int c_sel_unm  = 4;
   localparam int c_n_sel    = 5;

   localparam int c_reg_ctrl   = 0;
   localparam int c_reg_status = 1;
   localparam int c_reg_size   = 2;
   localparam int c_reg_cnt    = 3;
   localparam int c_n_reg      = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/vt512_wb_decode.sv
`default_nettype none
// ===========================================================================
// vt512_wb_decode : window check plus one-hot region / control-register decode
// Revision        : 1.0
// ===========================================================================
module vt512_wb_decode
   import vt512_pkg::*;
(
   input  logic               cyc_i,
   input  logic               stb_i,
   input  logic [31:0]        adr_i,
   output logic               req_o,
   output logic [c_n_sel-1:0] sel_o,
   output logic [c_n_reg-1:0] creg_o
);

   logic [7:0] w_rgn;
   logic [5:0] w_ofs;
   logic       w_unused;

   assign w_rgn    = adr_i[15:8];
   assign w_ofs    = adr_i[7:2];
   assign w_unused = &{1'b0, adr_i[1:0]};
   assign req_o    = cyc_i & stb_i & (adr_i[31:16] == c_base);

   always_comb begin
      sel_o  = '0;
      creg_o = '0;
      case (w_rgn)
         c_rgn_ctrl: sel_o[c_sel_ctrl] = 1'b1;
         c_rgn_wgt:  sel_o[c_sel_wgt]  = 1'b1;
         c_rgn_bias: sel_o[c_sel_bias] = 1'b1;
         c_rgn_img:  sel_o[c_sel_img]  = 1'b1;
         default:    sel_o[c_sel_unm]  = 1'b1;
      endcase
      // Offsets are only meaningful inside the control region
      if (w_rgn == c_rgn_ctrl) begin
         case (w_ofs)
            c_ofs_ctrl:   creg_o[c_reg_ctrl]   = 1'b1;
            c_ofs_status: creg_o[c_reg_status] = 1'b1;
            c_ofs_size:   creg_o[c_reg_size]   = 1'b1;
            c_ofs_cnt:    creg_o[c_reg_cnt]    = 1'b1;
            default:      ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/vt512_ctrl.sv
`default_nettype none
// ===========================================================================
// vt512_ctrl : Wishbone CSRs, weight/bias write ports, image stream, load/run/done FSM
// Revision   : 1.0
// ===========================================================================
module vt512_ctrl
   import vt512_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int MAX_IMAGE_SIZE = 512,
   parameter int CNT_W          = $clog2(MAX_IMAGE_SIZE*MAX_IMAGE_SIZE) + 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wbs_stb_i,
   input  logic                  wbs_cyc_i,
   input  logic                  wbs_we_i,
   input  logic [3:0]            wbs_sel_i,
   input  logic [31:0]           wbs_adr_i,
   input  logic [31:0]           wbs_dat_i,
   output logic                  wbs_ack_o,
   output logic [31:0]           wbs_dat_o,
   output logic                  wgt_we,
   output logic [5:0]            wgt_addr,
   output logic [DATA_WIDTH-1:0] wgt_data,
   output logic                  bias_we,
   output logic [5:0]            bias_addr,
   output logic [DATA_WIDTH-1:0] bias_data,
   output logic                  img_valid,
   input  logic                  img_ready,
   output logic [DATA_WIDTH-1:0] img_data,
   output logic                  img_last,
   output logic                  core_start,
   input  logic                  core_done,
   output logic [2:0]            irq
);

   localparam int              c_max_words = MAX_IMAGE_SIZE * MAX_IMAGE_SIZE;
   localparam logic [CNT_W-1:0] c_max_cnt  = CNT_W'(c_max_words);

   logic               w_req;
   logic [c_n_sel-1:0] w_sel;
   logic [c_n_reg-1:0] w_creg;
   logic               w_img_hs, w_accept, w_wr, w_ctrl_wr, w_clear, w_start, w_img_wr, w_last;
   logic               w_unused;
   logic [31:0]        rdata_d;

   state_e                state_q;
   logic                  ack_q, irq_en_q, done_q, overflow_q, size_err_q;
   logic                  irq_done_q, irq_ovf_q, core_start_q;
   logic [31:0]           dat_q;
   logic [CNT_W-1:0]      img_size_q, img_cnt_q;
   logic                  wgt_we_q, bias_we_q, img_valid_q;
   logic [5:0]            wgt_addr_q, bias_addr_q;
   logic [DATA_WIDTH-1:0] wgt_data_q, bias_data_q, img_data_q;

   vt512_wb_decode u_decode (
      .cyc_i  (wbs_cyc_i),
      .stb_i  (wbs_stb_i),
      .adr_i  (wbs_adr_i),
      .req_o  (w_req),
      .sel_o  (w_sel),
      .creg_o (w_creg)
   );

   assign w_unused = &{1'b0, wbs_sel_i};

   // A pending image word blocks further image requests; other accesses still get
   // through so a clear can abort the stalled transfer.
   assign w_img_hs  = img_valid_q & img_ready;
   assign w_accept  = w_req & ~ack_q & ~w_img_hs & ~(img_valid_q & w_sel[c_sel_img]);
   assign w_wr      = w_accept & wbs_we_i;
   assign w_ctrl_wr = w_wr & w_creg[c_reg_ctrl];
   assign w_clear   = w_ctrl_wr & wbs_dat_i[1];
   assign w_start   = w_ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];
   assign w_img_wr  = w_wr & w_sel[c_sel_img];
   assign w_last    = (img_cnt_q == img_size_q - CNT_W'(1));

   always_comb begin
      rdata_d = '0;
      if (w_creg[c_reg_ctrl])   rdata_d = {29'b0, irq_en_q, 2'b0};
      if (w_creg[c_reg_status]) rdata_d = {27'b0, size_err_q, overflow_q, done_q, state_q};
      if (w_creg[c_reg_size])   rdata_d = {{(32-CNT_W){1'b0}}, img_size_q};
      if (w_creg[c_reg_cnt])    rdata_d = {{(32-CNT_W){1'b0}}, img_cnt_q};
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         ack_q        <= 1'b0;
         dat_q        <= '0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
         size_err_q   <= 1'b0;
         irq_done_q   <= 1'b0;
         irq_ovf_q    <= 1'b0;
         core_start_q <= 1'b0;
         img_size_q   <= '0;
         img_cnt_q    <= '0;
         wgt_we_q     <= 1'b0;
         wgt_addr_q   <= '0;
         wgt_data_q   <= '0;
         bias_we_q    <= 1'b0;
         bias_addr_q  <= '0;
         bias_data_q  <= '0;
         img_valid_q  <= 1'b0;
         img_data_q   <= '0;
      end else begin
         ack_q        <= 1'b0;
         dat_q        <= '0;
         wgt_we_q     <= 1'b0;
         bias_we_q    <= 1'b0;
         irq_ovf_q    <= 1'b0;
         core_start_q <= 1'b0;

         // An image write in LOAD is acked later, after its stream handshake
         if (w_accept) begin
            ack_q <= ~(w_img_wr & (state_q == ST_LOAD));
            if (!wbs_we_i) dat_q <= rdata_d;
         end

         if (w_wr && w_sel[c_sel_wgt]) begin
            wgt_we_q   <= 1'b1;
            wgt_addr_q <= wbs_adr_i[7:2];
            wgt_data_q <= wbs_dat_i[DATA_WIDTH-1:0];
         end
         if (w_wr && w_sel[c_sel_bias]) begin
            bias_we_q   <= 1'b1;
            bias_addr_q <= wbs_adr_i[7:2];
            bias_data_q <= wbs_dat_i[DATA_WIDTH-1:0];
         end

         if (w_img_wr) begin
            if (state_q == ST_LOAD) begin
               img_valid_q <= 1'b1;
               img_data_q  <= wbs_dat_i[DATA_WIDTH-1:0];
            end else begin
               overflow_q <= 1'b1;
               irq_ovf_q  <= irq_en_q;
            end
         end

         if (w_img_hs) begin
            img_valid_q <= 1'b0;
            img_cnt_q   <= img_cnt_q + CNT_W'(1);
            if (w_req && w_sel[c_sel_img] && wbs_we_i && !ack_q) ack_q <= 1'b1;
            if (w_last) begin
               state_q      <= ST_RUN;
               core_start_q <= 1'b1;
            end
         end

         if (w_wr && w_creg[c_reg_size]) begin
            if (wbs_dat_i > 32'(c_max_words)) img_size_q <= c_max_cnt;
            else                              img_size_q <= wbs_dat_i[CNT_W-1:0];
         end

         if (w_ctrl_wr) irq_en_q <= wbs_dat_i[2];
         if (w_start)   irq_done_q <= 1'b0;

         if (state_q == ST_RUN && core_done) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            irq_done_q <= irq_en_q;
         end

         if (w_start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            done_q <= 1'b0;
            if (img_size_q == '0) begin
               size_err_q <= 1'b1;
               state_q    <= ST_IDLE;
            end else begin
               img_cnt_q <= '0;
               state_q   <= ST_LOAD;
            end
         end

         if (w_clear) begin
            state_q      <= ST_IDLE;
            img_cnt_q    <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            size_err_q   <= 1'b0;
            irq_done_q   <= 1'b0;
            irq_ovf_q    <= 1'b0;
            core_start_q <= 1'b0;
            img_valid_q  <= 1'b0;
         end
      end
   end

   assign wbs_ack_o  = ack_q;
   assign wbs_dat_o  = dat_q;
   assign wgt_we     = wgt_we_q;
   assign wgt_addr   = wgt_addr_q;
   assign wgt_data   = wgt_data_q;
   assign bias_we    = bias_we_q;
   assign bias_addr  = bias_addr_q;
   assign bias_data  = bias_data_q;
   assign img_valid  = img_valid_q;
   assign img_data   = img_data_q;
   assign img_last   = img_valid_q & w_last;
   assign core_start = core_start_q;
   assign irq        = {1'b0, irq_ovf_q, irq_done_q};

endmodule
`default_nettype wire

// File: doc/vt512_ctrl.md
# vt512_ctrl

Wishbone-facing controller for the VT512 accelerator. It decodes the 0x414E_xxxx user window and owns the control/status registers. It drives write strobes into the weight and bias memories and forwards image words to the image-capture datapath over a valid/ready stream with Wishbone backpressure. A load/run/done state machine sequences the compute core and raises the completion IRQ.

## Interface
- DATA_WIDTH, 32, Wishbone and stream data width
- MAX_IMAGE_SIZE, 512, max image side in pixels; word-count limit is MAX_IMAGE_SIZE*MAX_IMAGE_SIZE
- CNT_W, $clog2(MAX_IMAGE_SIZE*MAX_IMAGE_SIZE)+1 (19), image word counter width

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset; synchronous, active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone request
- wbs_sel_i  in  4  byte selects; ignored, full-word access only
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  registered read data
- wgt_we  out  1  weight memory write strobe
- wgt_addr  out  6  weight word index
- wgt_data  out  DATA_WIDTH  weight write data
- bias_we, bias_addr[5:0], bias_data  out  bias memory write port; same semantics as the weight port
- img_valid  out  1  image word valid
- img_ready  in  1  capture accepts word
- img_data  out  DATA_WIDTH  image word
- img_last  out  1  final word of the frame
- core_start  out  1  one-cycle compute start pulse
- core_done  in  1  compute-complete pulse
- irq  out  3  [0] done, [1] overflow, [2] tied 0

## Operation
- Decode: the request is valid when cyc&stb and adr[31:16]==16'h414E. Region is adr[15:8]:
  - 0x00 control
  - 0x57 weight
  - 0x42 bias
  - 0x49 image
  - any other region is unmapped
- Word index = adr[7:2].
- Control registers:
  - 0x00 CTRL (W): bit0 start, self-clearing; bit1 clear; bit2 irq_en, stored. A read returns {29'b0, irq_en, 2'b0}.
  - 0x04 STATUS (R): [1:0] state, [2] done, [3] overflow sticky, [4] size_err sticky.
  - 0x08 IMG_SIZE (RW): word count. Writes above the limit clamp to MAX_IMAGE_SIZE². Reset value is 0.
  - 0x0C IMG_CNT (R): words accepted in the current frame.
- Weight/bias write: wgt_we (or bias_we) pulses for exactly 1 cycle, coincident with ack, carrying addr=index and data=wbs_dat_i. Reads of these regions return 0.
- Image write during LOAD: register img_data and raise img_valid. Hold both until img_ready is sampled high. Ack in the cycle after the handshake, then increment IMG_CNT. img_last = (IMG_CNT == IMG_SIZE-1) while valid.
- Image write outside LOAD: ack and drop the word, set overflow, and pulse irq[1] if irq_en.
- Unmapped region or unmapped control offset: ack, writes have no effect, reads return 0.
- FSM states:
  - IDLE=0: on start with IMG_SIZE==0, set size_err and stay in IDLE. On start with a nonzero size, clear IMG_CNT and go to LOAD.
  - LOAD=1: when the last word handshakes, go to RUN.
  - RUN=2: core_start pulses in the first RUN cycle. When core_done is seen, go to DONE, set done, and set irq[0] if irq_en.
  - DONE=3: start behaves as in IDLE, with done cleared. Clear returns to IDLE.
- Clear, in any state: go to IDLE, zero IMG_CNT, and clear done, overflow, size_err and irq. Drop img_valid even if no handshake occurred; the pending Wishbone cycle is still acked.
- irq[0] is a level signal, cleared by clear or start. irq[1] is a 1-cycle pulse.
- If start and clear are written in the same word, clear wins.

## Timing
- Reset state:
  - state=IDLE; all registers 0
  - wbs_ack_o=0, wbs_dat_o=0
  - wgt_we=bias_we=0, img_valid=0, img_last=0
  - core_start=0, irq=0
- Non-image access: ack exactly 1 cycle after the request is first sampled. wbs_dat_o is valid with ack.
- Ack is never asserted on two consecutive cycles. A held stb gets a new ack only after a deassert-free gap of 1 cycle, i.e. every other cycle.
- Image access latency: minimum 2 cycles, stretched by img_ready low.
- core_done arriving in the same cycle as core_start is honoured.
- core_done arriving outside RUN is ignored.
- Reset mid-transfer: img_valid drops next edge and the pending request gets no ack.

## Structure
- Package vt512_pkg: base 16'h414E, region codes, control offsets, STATUS bit positions, state enum (2-bit typedef).
- Sub-module vt512_wb_decode: combinational region/offset decode → one-hot select. All sequencing stays in vt512_ctrl.

## Test plan
- CTRL write 0x4 then CTRL read → irq_en stored; read data 0x4; ack high 1 cycle after stb.
- Write 0xDEADBEEF to 0x414E_5714 → wgt_we=1 for 1 cycle, wgt_addr=5, wgt_data=0xDEADBEEF; bias_we stays 0.
- IMG_SIZE=4, start, 4 image writes with img_ready low 3 cycles on word 2 → ack stretched 3 cycles; img_last on word 4 only; core_start one pulse; core_done → STATUS=0x7 (state=3, done=1), irq[0]=1.
- Start with IMG_SIZE=0 → state stays 0, STATUS[4]=1, no core_start.
- Image write in IDLE with irq_en=1 → acked, img_valid stays 0, STATUS[3]=1, irq[1] pulses 1 cycle.
- Clear during LOAD with img_valid pending → IDLE next cycle, img_valid=0, IMG_CNT=0; wb_rst_i during LOAD → all outputs at reset values.
